// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment definitions.
// Segment codes (active-low, a=bit0), DP bit index, segment word type.
package seg7_pkg;

  typedef logic [7:0] seg_word_t;

  localparam int SEG_DP = 7;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1011000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0011000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/seg7_reverse_lut.sv
// seg7_reverse_lut: segment pattern -> hex nibble.
// i_seg: segments g..a active-low; o_hit: legal pattern; o_nib: value.
module seg7_reverse_lut
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic       o_hit,
  output logic [3:0] o_nib
);

  always_comb begin
    o_hit = 1'b1;
    o_nib = 4'h0;
    unique case (i_seg)
      SEG_0:   o_nib = 4'h0;
      SEG_1:   o_nib = 4'h1;
      SEG_2:   o_nib = 4'h2;
      SEG_3:   o_nib = 4'h3;
      SEG_4:   o_nib = 4'h4;
      SEG_5:   o_nib = 4'h5;
      SEG_6:   o_nib = 4'h6;
      SEG_7:   o_nib = 4'h7;
      SEG_8:   o_nib = 4'h8;
      SEG_9:   o_nib = 4'h9;
      SEG_A:   o_nib = 4'hA;
      SEG_B:   o_nib = 4'hB;
      SEG_C:   o_nib = 4'hC;
      SEG_D:   o_nib = 4'hD;
      SEG_E:   o_nib = 4'hE;
      SEG_F:   o_nib = 4'hF;
      default: o_hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: debounced capture of a multiplexed 7-seg bus.
// SEG/AN in (active-low); HEX/DP/VALID/ERR per digit; UPD/FRAME pulses.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NDIG   = 4,
  parameter int STABLE = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  seg_word_t         SEG,
  input  logic [NDIG-1:0]   AN,
  output logic [4*NDIG-1:0] HEX,
  output logic [NDIG-1:0]   DP,
  output logic [NDIG-1:0]   VALID,
  output logic [NDIG-1:0]   ERR,
  output logic              UPD,
  output logic              FRAME
);

  localparam int SW = 8 + NDIG;

  logic [SW-1:0]     w_bus;
  logic [SW-1:0]     r_smp;
  logic [3:0]        r_cnt;
  logic              w_same;
  logic [NDIG-1:0]   w_sel;
  logic              w_one;
  logic              w_cap;
  logic              w_hit;
  logic [3:0]        w_nib;

  logic [4*NDIG-1:0] r_hex, w_hex_n;
  logic [NDIG-1:0]   r_dp, w_dp_n;
  logic [NDIG-1:0]   r_val, w_val_n;
  logic [NDIG-1:0]   r_err, w_err_n;
  logic [NDIG-1:0]   r_seen, w_seen_n;
  logic              w_all;
  logic              r_upd;
  logic              r_frame;

  assign w_bus  = {AN, SEG};
  assign w_same = (w_bus == r_smp);
  assign w_sel  = ~r_smp[SW-1:8];

  // exactly one anode low
  assign w_one = (w_sel != '0) &&
                 ((w_sel & (w_sel - NDIG'(1))) == '0);

  // fires once per dwell, on the CNT STABLE-1 -> STABLE step
  assign w_cap = w_same && w_one &&
                 (r_cnt == 4'(STABLE - 1));

  seg7_reverse_lut u_lut (
    .i_seg (r_smp[6:0]),
    .o_hit (w_hit),
    .o_nib (w_nib)
  );

  always_comb begin
    w_hex_n = r_hex;
    w_dp_n  = r_dp;
    w_val_n = r_val;
    w_err_n = r_err;
    for (int i = 0; i < NDIG; i++) begin
      if (w_cap && w_sel[i]) begin
        w_dp_n[i] = ~r_smp[SEG_DP];
        if (w_hit) begin
          w_hex_n[4*i +: 4] = w_nib;
          w_val_n[i] = 1'b1;
          w_err_n[i] = 1'b0;
        end else begin
          w_val_n[i] = 1'b0;
          w_err_n[i] = 1'b1;
        end
      end
    end
  end

  assign w_seen_n = r_seen | w_sel;
  assign w_all    = &w_seen_n;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_smp   <= '1;
      r_cnt   <= '0;
      r_hex   <= '0;
      r_dp    <= '0;
      r_val   <= '0;
      r_err   <= '0;
      r_seen  <= '0;
      r_upd   <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      r_smp <= w_bus;
      if (!w_same)
        r_cnt <= '0;
      else if (r_cnt != 4'(STABLE))
        r_cnt <= r_cnt + 4'd1;
      r_hex   <= w_hex_n;
      r_dp    <= w_dp_n;
      r_val   <= w_val_n;
      r_err   <= w_err_n;
      r_upd   <= w_cap &&
                 ({w_hex_n, w_dp_n, w_val_n, w_err_n} !=
                  {r_hex, r_dp, r_val, r_err});
      r_frame <= w_cap && w_all;
      if (w_cap)
        r_seen <= w_all ? '0 : w_seen_n;
    end
  end

  assign HEX   = r_hex;
  assign DP    = r_dp;
  assign VALID = r_val;
  assign ERR   = r_err;
  assign UPD   = r_upd;
  assign FRAME = r_frame;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: randomized bench with a history-based model.
// Drives SEG/AN at negedge, compares all outputs at the next negedge.
module tb_seg7_scan_capture;

  localparam int NDIG   = 4;
  localparam int STABLE = 4;

  localparam logic [6:0] TBL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [7:0]      SEG = 8'hFF;
  logic [NDIG-1:0] AN  = '1;
  logic [15:0]     HEX;
  logic [3:0]      DP, VALID, ERR;
  logic            UPD, FRAME;

  int checks = 0;
  int errors = 0;

  seg7_scan_capture #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .CLK(CLK), .RST(RST), .SEG(SEG), .AN(AN),
    .HEX(HEX), .DP(DP), .VALID(VALID), .ERR(ERR),
    .UPD(UPD), .FRAME(FRAME)
  );

  always #5 CLK = ~CLK;

  // Model: a capture happens when the last STABLE+1 sampled bus
  // values are identical and the run has just reached that length.
  // Reset behaves like the bus having just become all ones.
  logic [11:0] h [$];
  logic [15:0] m_hex = '0;
  logic [3:0]  m_dp = '0, m_val = '0, m_err = '0, m_seen = '0;
  logic        m_upd = 1'b0, m_frame = 1'b0;

  function automatic int lookup(logic [6:0] s);
    for (int k = 0; k < 16; k++)
      if (TBL[k] == s) return k;
    return -1;
  endfunction

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      h.delete();
      h.push_back('1);
      m_hex = '0; m_dp = '0; m_val = '0; m_err = '0;
      m_seen = '0; m_upd = 1'b0; m_frame = 1'b0;
    end else begin : mdl
      logic [11:0] b;
      logic [27:0] old;
      bit cap;
      int n, d, code;
      b = {AN, SEG};
      h.push_back(b);
      if (h.size() > STABLE + 2) void'(h.pop_front());
      cap = 0;
      if (h.size() >= STABLE + 1) begin
        cap = 1;
        for (int k = h.size() - STABLE - 1; k < h.size(); k++)
          if (h[k] != b) cap = 0;
        if (h.size() == STABLE + 2 && h[0] == b) cap = 0;
      end
      m_upd = 1'b0;
      m_frame = 1'b0;
      n = 0; d = 0;
      for (int k = 0; k < NDIG; k++)
        if (!b[8+k]) begin n++; d = k; end
      if (cap && n == 1) begin
        old = {m_hex, m_dp, m_val, m_err};
        code = lookup(b[6:0]);
        if (code >= 0) begin
          m_hex[4*d +: 4] = code[3:0];
          m_val[d] = 1'b1;
          m_err[d] = 1'b0;
        end else begin
          m_val[d] = 1'b0;
          m_err[d] = 1'b1;
        end
        m_dp[d] = ~b[7];
        m_upd = (old != {m_hex, m_dp, m_val, m_err});
        m_seen[d] = 1'b1;
        if (&m_seen) begin
          m_frame = 1'b1;
          m_seen = '0;
        end
      end
    end
  end

  logic [29:0] obs, mexp;
  assign obs  = {HEX, DP, VALID, ERR, UPD, FRAME};
  assign mexp = {m_hex, m_dp, m_val, m_err, m_upd, m_frame};

  task automatic test_reset();
    #1 RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (obs !== 30'd0) begin
      errors++;
      $display("FAIL reset_state got=%h want=0", obs);
    end
    RST = 1'b1;
    repeat (12) begin
      @(negedge CLK);
      checks++;
      if (obs !== 30'd0 || mexp !== 30'd0) begin
        errors++;
        $display("FAIL idle got=%h want=0", obs);
      end
    end
  endtask

  task automatic test_single();
    AN = 4'b1110; SEG = 8'hA4;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      checks++;
      if (obs !== mexp) begin
        errors++;
        $display("FAIL single_c%0d got=%h want=%h", c, obs, mexp);
      end
      checks++;
      if (c == 4 && VALID[0] !== 1'b0) begin
        errors++;
        $display("FAIL single_early got=%b want=0", VALID[0]);
      end else if (c == 5 &&
          {HEX[3:0], VALID[0], DP[0], UPD} !== 7'b0010_1_0_1) begin
        errors++;
        $display("FAIL single_cap got=%b want=0010101",
                 {HEX[3:0], VALID[0], DP[0], UPD});
      end else if (c != 5 && UPD !== 1'b0) begin
        errors++;
        $display("FAIL single_upd c=%0d got=%b want=0", c, UPD);
      end
    end
  endtask

  task automatic test_scan();
    logic [7:0] pat [4];
    int frames;
    pat = '{8'h99, 8'h92, 8'h82, 8'h00};
    frames = 0;
    for (int d = 0; d < 4; d++) begin
      AN = ~(4'b1 << d); SEG = pat[d];
      repeat (6) begin
        @(negedge CLK);
        if (FRAME) frames++;
        checks++;
        if (obs !== mexp) begin
          errors++;
          $display("FAIL scan_d%0d got=%h want=%h", d, obs, mexp);
        end
      end
    end
    repeat (2) begin
      @(negedge CLK);
      if (FRAME) frames++;
    end
    checks++;
    if (HEX !== 16'h8654 || DP !== 4'b1000) begin
      errors++;
      $display("FAIL scan_val got=%h/%b want=8654/1000", HEX, DP);
    end
    checks++;
    if (frames != 1) begin
      errors++;
      $display("FAIL scan_frame got=%0d want=1", frames);
    end
  endtask

  task automatic test_err();
    AN = 4'b1101; SEG = 8'hFF;
    repeat (8) begin
      @(negedge CLK);
      checks++;
      if (obs !== mexp) begin
        errors++;
        $display("FAIL err_blank got=%h want=%h", obs, mexp);
      end
    end
    checks++;
    if ({ERR[1], VALID[1], HEX[7:4]} !== 6'b1_0_0101) begin
      errors++;
      $display("FAIL err_miss got=%b want=100101",
               {ERR[1], VALID[1], HEX[7:4]});
    end
    SEG = 8'hC6;
    repeat (8) begin
      @(negedge CLK);
      checks++;
      if (obs !== mexp) begin
        errors++;
        $display("FAIL err_c got=%h want=%h", obs, mexp);
      end
    end
    checks++;
    if ({ERR[1], VALID[1], HEX[7:4]} !== 6'b0_1_1100) begin
      errors++;
      $display("FAIL err_hit got=%b want=011100",
               {ERR[1], VALID[1], HEX[7:4]});
    end
  endtask

  task automatic test_glitch();
    AN = 4'b1110;
    for (int c = 0; c < 28; c++) begin
      if (c < 18)
        SEG = ((c / 3) % 2 == 0) ? 8'hF9 : 8'hB0;
      else begin
        AN = 4'b1100; SEG = 8'hA4;
      end
      @(negedge CLK);
      checks++;
      if (obs !== mexp || UPD !== 1'b0) begin
        errors++;
        $display("FAIL glitch_c%0d got=%h want=%h", c, obs, mexp);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    AN = 4'b1110; SEG = 8'h92;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    checks++;
    if (obs !== 30'd0) begin
      errors++;
      $display("FAIL rst_mid got=%h want=0", obs);
    end
    @(negedge CLK);
    RST = 1'b1;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (lat < 0 && VALID[0] === 1'b1) lat = c;
      checks++;
      if (obs !== mexp) begin
        errors++;
        $display("FAIL rst_re c=%0d got=%h want=%h", c, obs, mexp);
      end
    end
    checks++;
    if (lat != STABLE + 1) begin
      errors++;
      $display("FAIL rst_latency got=%0d want=%0d", lat, STABLE + 1);
    end
  endtask

  task automatic test_random();
    int d, dw;
    for (int t = 0; t < 200; t++) begin
      d = $urandom_range(0, NDIG - 1);
      AN = ~(4'b1 << d);
      if ($urandom_range(0, 7) == 0) AN = 4'($urandom);
      if ($urandom_range(0, 4) == 0)
        SEG = 8'($urandom);
      else
        SEG = {1'($urandom), TBL[$urandom_range(0, 15)]};
      dw = $urandom_range(1, 8);
      repeat (dw) begin
        @(negedge CLK);
        checks++;
        if (obs !== mexp) begin
          errors++;
          $display("FAIL random_t%0d got=%h want=%h", t, obs, mexp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_scan();
    test_err();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
